// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between N_REQ byte-stream requesters.
// A grant lasts for a whole packet (until a byte flagged last) or until the owner stalls too long.
module uart_tx_arbiter #(
  parameter int N_REQ        = 4,
  parameter int DATA_BITS    = 8,
  parameter int HOLD_TIMEOUT = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_REQ-1:0]             req_valid,
  input  logic [N_REQ*DATA_BITS-1:0]   req_data,
  input  logic [N_REQ-1:0]             req_last,
  output logic [N_REQ-1:0]             req_ready,
  output logic                         tx_start,
  output logic [DATA_BITS-1:0]         tx_data,
  input  logic                         tx_ready,
  output logic                         grant_valid,
  output logic [$clog2(N_REQ)-1:0]     grant_id,
  output logic                         busy
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = (HOLD_TIMEOUT > 0) ? $clog2(HOLD_TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, HOLD, START, WAIT_TX} state_t;

  state_t               state, state_next;
  logic [ID_W-1:0]      ptr, ptr_next;
  logic [ID_W-1:0]      grant_id_next;
  logic                 grant_valid_next;
  logic [DATA_BITS-1:0] tx_data_next;
  logic                 tx_start_next;
  logic                 last_q, last_next;
  logic [CNT_W-1:0]     cnt, cnt_next;

  logic [2*N_REQ-1:0]   rot;
  logic [ID_W-1:0]      offset;
  logic [ID_W:0]        win_sum;
  logic [ID_W-1:0]      winner;
  logic [ID_W-1:0]      next_id;
  logic                 owner_valid;
  logic                 owner_last;
  logic [DATA_BITS-1:0] owner_data;
  logic                 accept;
  logic                 timed_out;

  // Rotate the request vector so that bit 0 is the requester at ptr; the lowest set bit wins.
  always_comb begin
    rot    = {req_valid, req_valid} >> ptr;
    offset = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot[k]) offset = ID_W'(k);
    end
    win_sum = {1'b0, ptr} + {1'b0, offset};
    if (win_sum >= (ID_W+1)'(N_REQ)) win_sum = win_sum - (ID_W+1)'(N_REQ);
    winner = win_sum[ID_W-1:0];
  end

  always_comb begin
    owner_valid = 1'b0;
    owner_last  = 1'b0;
    owner_data  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_id == ID_W'(i)) begin
        owner_valid = req_valid[i];
        owner_last  = req_last[i];
        owner_data  = req_data[i*DATA_BITS +: DATA_BITS];
      end
    end
  end

  assign accept    = (state == HOLD) && tx_ready && owner_valid;
  assign next_id   = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
  assign timed_out = (HOLD_TIMEOUT != 0) && ((int'(cnt) + 1) >= HOLD_TIMEOUT);
  assign busy      = (state != IDLE);

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (accept && (grant_id == ID_W'(i))) req_ready[i] = 1'b1;
    end
  end

  always_comb begin
    state_next       = state;
    ptr_next         = ptr;
    grant_id_next    = grant_id;
    grant_valid_next = grant_valid;
    tx_data_next     = tx_data;
    tx_start_next    = 1'b0;
    last_next        = last_q;
    cnt_next         = cnt;
    unique case (state)
      IDLE: begin
        if (|req_valid) begin
          grant_id_next    = winner;
          grant_valid_next = 1'b1;
          cnt_next         = '0;
          state_next       = HOLD;
        end
      end
      HOLD: begin
        if (accept) begin
          tx_data_next  = owner_data;
          last_next     = owner_last;
          tx_start_next = 1'b1;
          cnt_next      = '0;
          state_next    = START;
        end else begin
          // Saturate rather than wrap so a stalled owner can never look fresh again.
          if (cnt != '1) cnt_next = cnt + 1'b1;
          if (timed_out) begin
            grant_valid_next = 1'b0;
            ptr_next         = next_id;
            state_next       = IDLE;
          end
        end
      end
      START: begin
        state_next = WAIT_TX;
      end
      WAIT_TX: begin
        if (tx_ready) begin
          if (last_q) begin
            grant_valid_next = 1'b0;
            ptr_next         = next_id;
            state_next       = IDLE;
          end else begin
            cnt_next   = '0;
            state_next = HOLD;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= '0;
      grant_id    <= '0;
      grant_valid <= 1'b0;
      tx_data     <= '0;
      tx_start    <= 1'b0;
      last_q      <= 1'b0;
      cnt         <= '0;
    end else begin
      state       <= state_next;
      ptr         <= ptr_next;
      grant_id    <= grant_id_next;
      grant_valid <= grant_valid_next;
      tx_data     <= tx_data_next;
      tx_start    <= tx_start_next;
      last_q      <= last_next;
      cnt         <= cnt_next;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester drivers, a behavioural UART that is busy 40 cycles per byte,
// and a round-robin packet-order model that predicts the byte/owner sequence.
module tb_uart_tx_arbiter;

  localparam int N    = 4;
  localparam int DB   = 8;
  localparam int TO   = 16;
  localparam int BYTE_CYCLES = 4 * 10;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N*DB-1:0] req_data;
  logic [N-1:0]    req_last;
  logic [N-1:0]    req_ready;
  logic            tx_start;
  logic [DB-1:0]   tx_data;
  logic            tx_ready;
  logic            grant_valid;
  logic [1:0]      grant_id;
  logic            busy;

  typedef struct {
    logic [7:0] data;
    bit         last;
    int         gap;
  } item_t;

  item_t      drvq [N][$];
  int         gapcnt [N];
  logic [7:0] exp_bytes[$], obs_bytes[$];
  int         exp_ids[$], obs_ids[$];
  int         mptr;
  int         uart_cnt;
  bit         force_low;
  bit         ready_seen;
  bit         start_seen;
  logic [N-1:0] acc;
  int         checks = 0;
  int         errors = 0;

  uart_tx_arbiter #(.N_REQ(N), .DATA_BITS(DB), .HOLD_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data), .tx_ready(tx_ready),
    .grant_valid(grant_valid), .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic presentInputs();
    for (int r = 0; r < N; r++) begin
      if (gapcnt[r] > 0) begin
        gapcnt[r]--;
        req_valid[r] = 1'b0;
      end else if (drvq[r].size() > 0) begin
        req_valid[r]            = 1'b1;
        req_data[r*DB +: DB]    = drvq[r][0].data;
        req_last[r]             = drvq[r][0].last;
      end else begin
        req_valid[r]            = 1'b0;
        req_data[r*DB +: DB]    = '0;
        req_last[r]             = 1'b0;
      end
    end
  endtask

  // One clock cycle: sample and check invariants mid-cycle, then advance drivers and the UART model.
  task automatic applyStimulus();
    @(negedge clk);
    checkOutput("ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
    if (!busy) checkOutput("ready_in_idle", 32'(req_ready), 32'd0);
    acc        = req_ready & req_valid;
    start_seen = tx_start;
    if (tx_start) begin
      checkOutput("start_needs_ready", 32'(ready_seen), 32'd1);
      ready_seen = 1'b0;
      obs_bytes.push_back(tx_data);
      obs_ids.push_back(int'(grant_id));
    end
    @(posedge clk);
    #1;
    if (reset) begin
      for (int r = 0; r < N; r++) begin
        drvq[r].delete();
        gapcnt[r] = 0;
      end
    end else begin
      for (int r = 0; r < N; r++) begin
        if (acc[r]) begin
          void'(drvq[r].pop_front());
          if (drvq[r].size() > 0) gapcnt[r] = drvq[r][0].gap;
        end
      end
    end
    if (start_seen) uart_cnt = BYTE_CYCLES;
    else if (uart_cnt > 0) uart_cnt--;
    tx_ready = (uart_cnt == 0) && !force_low;
    if (tx_ready) ready_seen = 1'b1;
    presentInputs();
  endtask

  task automatic addByte(input int r, input logic [7:0] d, input bit last, input int gap);
    item_t it;
    it.data = d;
    it.last = last;
    it.gap  = gap;
    drvq[r].push_back(it);
  endtask

  // Reference: whole packets are served round-robin, starting the search at the pointer.
  task automatic buildExpected();
    item_t mq [N][$];
    int total;
    int r;
    item_t it;
    for (int i = 0; i < N; i++) mq[i] = drvq[i];
    forever begin
      total = 0;
      for (int i = 0; i < N; i++) total += mq[i].size();
      if (total == 0) break;
      r = mptr;
      while (mq[r].size() == 0) r = (r + 1) % N;
      do begin
        it = mq[r].pop_front();
        exp_bytes.push_back(it.data);
        exp_ids.push_back(r);
      end while (!it.last && mq[r].size() > 0);
      mptr = (r + 1) % N;
    end
  endtask

  task automatic launch();
    buildExpected();
    presentInputs();
  endtask

  task automatic compareScoreboard(input string tag);
    int n;
    checkOutput({tag, "_count"}, 32'(obs_bytes.size()), 32'(exp_bytes.size()));
    n = (obs_bytes.size() < exp_bytes.size()) ? obs_bytes.size() : exp_bytes.size();
    for (int i = 0; i < n; i++) begin
      checkOutput({tag, "_byte"}, 32'(obs_bytes[i]), 32'(exp_bytes[i]));
      checkOutput({tag, "_owner"}, 32'(obs_ids[i]), 32'(exp_ids[i]));
    end
    obs_bytes.delete(); exp_bytes.delete();
    obs_ids.delete();   exp_ids.delete();
  endtask

  task automatic runUntilDone(input string tag, input int budget);
    int n;
    bit done;
    int pending;
    n = 0;
    done = 1'b0;
    while (!done && n < budget) begin
      applyStimulus();
      n++;
      pending = 0;
      for (int r = 0; r < N; r++) pending += drvq[r].size();
      done = (pending == 0) && !busy && tx_ready;
    end
    checkOutput({tag, "_done"}, 32'(done), 32'd1);
    compareScoreboard(tag);
  endtask

  task automatic waitStart(input string tag, output int n);
    n = 0;
    do begin
      applyStimulus();
      n++;
    end while (!start_seen && n < 50);
    checkOutput({tag, "_start_seen"}, 32'(start_seen), 32'd1);
  endtask

  task automatic doReset();
    reset = 1'b1;
    applyStimulus();
    applyStimulus();
    reset = 1'b0;
    mptr  = 0;
  endtask

  initial begin
    int n, held, guard, total;
    reset = 1'b1; req_valid = '0; req_data = '0; req_last = '0;
    tx_ready = 1'b1; uart_cnt = 0; force_low = 1'b0; ready_seen = 1'b1;
    mptr = 0;
    for (int r = 0; r < N; r++) gapcnt[r] = 0;

    doReset();
    checkOutput("rst_tx_start", 32'(tx_start), 32'd0);
    checkOutput("rst_grant_valid", 32'(grant_valid), 32'd0);
    checkOutput("rst_grant_id", 32'(grant_id), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
    checkOutput("rst_tx_data", 32'(tx_data), 32'd0);

    // Single-byte packet, including request-to-start latency.
    addByte(0, 8'hA5, 1'b1, 0);
    launch();
    waitStart("t1", n);
    checkOutput("t1_latency", 32'(n), 32'd3);
    runUntilDone("t1", 500);
    checkOutput("t1_grant_valid", 32'(grant_valid), 32'd0);
    checkOutput("t1_busy", 32'(busy), 32'd0);

    // Multi-byte packet is atomic against a waiting requester.
    doReset();
    addByte(0, 8'h11, 1'b0, 0); addByte(0, 8'h22, 1'b0, 0); addByte(0, 8'h33, 1'b1, 0);
    addByte(1, 8'h44, 1'b1, 0);
    launch();
    runUntilDone("t2", 1000);

    // Pointer moves past the last owner.
    doReset();
    addByte(2, 8'h02, 1'b1, 0);
    launch();
    runUntilDone("t3a", 500);
    for (int r = 0; r < N; r++) addByte(r, 8'hA0 + 8'(r), 1'b1, 0);
    launch();
    runUntilDone("t3b", 1000);

    // Stalled owner loses its grant after TO stalled HOLD cycles.
    doReset();
    addByte(0, 8'h01, 1'b0, 0);
    addByte(1, 8'h02, 1'b1, 0);
    exp_bytes.push_back(8'h01); exp_ids.push_back(0);
    exp_bytes.push_back(8'h02); exp_ids.push_back(1);
    mptr = 2;
    presentInputs();
    waitStart("t4", n);
    held = 0;
    guard = 0;
    while (guard < 300) begin
      applyStimulus();
      guard++;
      if (!(grant_valid && grant_id == 2'd0)) break;
      if (tx_ready) held++;
    end
    checkOutput("t4_hold_cycles", 32'(held), 32'(1 + TO));
    runUntilDone("t4", 500);

    // Reset while the UART is mid-byte.
    doReset();
    addByte(0, 8'h77, 1'b1, 0);
    launch();
    waitStart("t5", n);
    applyStimulus();
    applyStimulus();
    reset = 1'b1;
    applyStimulus();
    reset = 1'b0;
    mptr  = 0;
    checkOutput("t5_tx_start", 32'(tx_start), 32'd0);
    checkOutput("t5_grant_valid", 32'(grant_valid), 32'd0);
    checkOutput("t5_busy", 32'(busy), 32'd0);
    checkOutput("t5_req_ready", 32'(req_ready), 32'd0);
    runUntilDone("t5a", 200);
    addByte(3, 8'h5A, 1'b1, 0);
    launch();
    runUntilDone("t5b", 500);

    // Owner valid while the UART reports not-ready.
    doReset();
    force_low = 1'b1;
    tx_ready  = 1'b0;
    addByte(1, 8'h66, 1'b1, 0);
    launch();
    for (int i = 0; i < 10; i++) begin
      applyStimulus();
      checkOutput("t6_no_ready", 32'(req_ready), 32'd0);
      checkOutput("t6_no_start", 32'(tx_start), 32'd0);
    end
    checkOutput("t6_grant_valid", 32'(grant_valid), 32'd1);
    checkOutput("t6_grant_id", 32'(grant_id), 32'd1);
    force_low = 1'b0;
    runUntilDone("t6", 500);

    // Random packet mixes across rounds without reset, so the pointer carries over.
    doReset();
    for (int round = 0; round < 5; round++) begin
      total = 0;
      for (int r = 0; r < N; r++) begin
        int npk;
        npk = int'($urandom_range(0, 2));
        for (int p = 0; p < npk; p++) begin
          int len;
          len = int'($urandom_range(1, 3));
          for (int b = 0; b < len; b++) begin
            addByte(r, 8'($urandom), b == len - 1, (b == 0) ? 0 : int'($urandom_range(0, 50)));
            total++;
          end
        end
      end
      if (total == 0) addByte(round % N, 8'($urandom), 1'b1, 0);
      launch();
      runUntilDone("rnd", 4000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
